// File: rtl/enc_pkg.sv
// Shared types and default sizes for the sequential 8-to-3 encoder.
package enc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam int N_DEF = 8;
    localparam int W_DEF = 3;

endpackage

// File: rtl/encoder8_3_scan_prio_enc.sv
// Combinational priority encoder: index of the first set bit from either end,
// plus flags for "any bit set" and "exactly one bit set".
module prio_enc
    import enc_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic [N-1:0] i_vec,
    input  logic         i_msb_first,
    output logic [W-1:0] o_idx,
    output logic         o_any,
    output logic         o_onehot
);

    // Later loop iterations overwrite earlier ones, so the scan direction is
    // the reverse of the priority direction.
    always_comb begin
        o_idx = '0;
        if (i_msb_first) begin
            for (int i = 0; i < N; i++) begin
                if (i_vec[i]) o_idx = W'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (i_vec[i]) o_idx = W'(i);
            end
        end
    end

    assign o_any    = |i_vec;
    assign o_onehot = o_any && ((i_vec & (i_vec - N'(1))) == '0);

endmodule

// File: rtl/encoder8_3_scan.sv
// Sequential encoder: captures a multi-hot vector and emits one binary index per beat.
// Define ENC_BACK_TO_BACK_EN to accept the next vector on the final beat of the current one.
module encoder8_3_scan
    import enc_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int W        = W_DEF,
    parameter int PRIO_MSB = 0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [N-1:0] i_in_vec,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [W-1:0] o_out_code,
    output logic         o_out_last,
    output logic         o_busy
);

    state_t         r_state;
    state_t         w_stateNext;
    logic [N-1:0]   r_pend;
    logic [N-1:0]   w_pendNext;
    logic [W-1:0]   w_idx;
    logic           w_any;
    logic           w_onehot;
    logic [N-1:0]   w_clrMask;
    logic           w_beat;
    logic           w_accept;

    prio_enc #(
        .N (N),
        .W (W)
    ) u_prio_enc (
        .i_vec       (r_pend),
        .i_msb_first (PRIO_MSB != 0),
        .o_idx       (w_idx),
        .o_any       (w_any),
        .o_onehot    (w_onehot)
    );

    // Outputs come only from the pend register; pend is zero whenever IDLE.
    assign o_out_valid = (r_state == SCAN) && w_any;
    assign o_out_code  = w_idx;
    assign o_out_last  = (r_state == SCAN) && w_onehot;
    assign o_busy      = (r_state == SCAN);

`ifdef ENC_BACK_TO_BACK_EN
    assign o_in_ready = (r_state == IDLE) || (o_out_last && i_out_ready);
`else
    assign o_in_ready = (r_state == IDLE);
`endif

    assign w_clrMask = N'(1) << w_idx;
    assign w_beat    = o_out_valid && i_out_ready;
    assign w_accept  = i_in_valid && o_in_ready;

    always_comb begin
        w_stateNext = r_state;
        w_pendNext  = r_pend;
        case (r_state)
            IDLE: begin
                if (w_accept && (i_in_vec != '0)) begin
                    w_pendNext  = i_in_vec;
                    w_stateNext = SCAN;
                end
            end
            SCAN: begin
                if (w_beat) begin
                    w_pendNext = r_pend & ~w_clrMask;
                    if (w_onehot) begin
                        w_stateNext = IDLE;
                        // A zero vector taken here is dropped because pend stays zero.
                        if (w_accept && (i_in_vec != '0)) begin
                            w_pendNext  = i_in_vec;
                            w_stateNext = SCAN;
                        end
                    end
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_pendNext  = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_pend  <= '0;
        end else begin
            r_state <= w_stateNext;
            r_pend  <= w_pendNext;
        end
    end

endmodule

// File: tb/tb_encoder8_3_scan.sv
// Directed bench for encoder8_3_scan: one LSB-first and one MSB-first instance.
// Back-to-back expectations follow ENC_BACK_TO_BACK_EN.
module tb_encoder8_3_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic       inValid0, inReady0, outValid0, outReady0, outLast0, busy0;
    logic [7:0] inVec0;
    logic [2:0] outCode0;
    logic       inValid1, inReady1, outValid1, outReady1, outLast1, busy1;
    logic [7:0] inVec1;
    logic [2:0] outCode1;

    int vectorsApplied = 0;
    int miscompares    = 0;

    always #5 clk = ~clk;

    encoder8_3_scan #(.N(8), .W(3), .PRIO_MSB(0)) dutLsb (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (inValid0),
        .o_in_ready  (inReady0),
        .i_in_vec    (inVec0),
        .o_out_valid (outValid0),
        .i_out_ready (outReady0),
        .o_out_code  (outCode0),
        .o_out_last  (outLast0),
        .o_busy      (busy0)
    );

    encoder8_3_scan #(.N(8), .W(3), .PRIO_MSB(1)) dutMsb (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (inValid1),
        .o_in_ready  (inReady1),
        .i_in_vec    (inVec1),
        .o_out_valid (outValid1),
        .i_out_ready (outReady1),
        .o_out_code  (outCode1),
        .o_out_last  (outLast1),
        .o_busy      (busy1)
    );

    // Advance one edge and settle; inputs set before the call are sampled on that edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectorsApplied++;
        if ({inReady0, outValid0, outCode0, outLast0, busy0} !== {1'b1, 1'b0, 3'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL reset_lsb: got rdy=%b v=%b c=%0d l=%b b=%b, want rdy=1 v=0 c=0 l=0 b=0",
                     inReady0, outValid0, outCode0, outLast0, busy0);
        end
        vectorsApplied++;
        if ({inReady1, outValid1, outCode1, outLast1, busy1} !== {1'b1, 1'b0, 3'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL reset_msb: got rdy=%b v=%b c=%0d l=%b b=%b, want rdy=1 v=0 c=0 l=0 b=0",
                     inReady1, outValid1, outCode1, outLast1, busy1);
        end
        rst = 1'b0;
        inValid0 = 1'b1; inVec0 = 8'hA5; outReady0 = 1'b1;
        tick();
        inValid0 = 1'b0; inVec0 = 8'h00;
        vectorsApplied++;
        if ({outValid0, outCode0} !== {1'b1, 3'd0}) begin
            miscompares++;
            $display("[TB] FAIL reset_prebeat: got v=%b c=%0d, want v=1 c=0", outValid0, outCode0);
        end
        tick();
        rst = 1'b1;
        tick();
        tick();
        vectorsApplied++;
        if ({inReady0, outValid0, outCode0, outLast0, busy0} !== {1'b1, 1'b0, 3'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL reset_midscan: got rdy=%b v=%b c=%0d l=%b b=%b, want rdy=1 v=0 c=0 l=0 b=0",
                     inReady0, outValid0, outCode0, outLast0, busy0);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectorsApplied++;
            if (outValid0 !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL reset_nobeats[%0d]: got v=%b, want v=0", i, outValid0);
            end
        end
    endtask

    task automatic test_basic_scan();
        logic [2:0] expCode [4] = '{3'd1, 3'd2, 3'd5, 3'd7};
        inValid0 = 1'b1; inVec0 = 8'b1010_0110; outReady0 = 1'b1;
        tick();
        inValid0 = 1'b0; inVec0 = 8'h00;
        for (int i = 0; i < 4; i++) begin
            vectorsApplied++;
            if ({outValid0, outCode0, outLast0, busy0} !== {1'b1, expCode[i], (i == 3), 1'b1}) begin
                miscompares++;
                $display("[TB] FAIL basic_beat[%0d]: got v=%b c=%0d l=%b b=%b, want v=1 c=%0d l=%b b=1",
                         i, outValid0, outCode0, outLast0, busy0, expCode[i], (i == 3));
            end
            tick();
        end
        vectorsApplied++;
        if ({outValid0, busy0, inReady0} !== {1'b0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL basic_done: got v=%b b=%b rdy=%b, want v=0 b=0 rdy=1", outValid0, busy0, inReady0);
        end
    endtask

    task automatic test_stall();
        inValid0 = 1'b1; inVec0 = 8'h81; outReady0 = 1'b1;
        tick();
        inValid0 = 1'b0; inVec0 = 8'h00;
        vectorsApplied++;
        if ({outValid0, outCode0, outLast0} !== {1'b1, 3'd0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL stall_first: got v=%b c=%0d l=%b, want v=1 c=0 l=0", outValid0, outCode0, outLast0);
        end
        tick();
        outReady0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectorsApplied++;
            if ({outValid0, outCode0, outLast0, inReady0} !== {1'b1, 3'd7, 1'b1, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL stall_hold[%0d]: got v=%b c=%0d l=%b rdy=%b, want v=1 c=7 l=1 rdy=0",
                         i, outValid0, outCode0, outLast0, inReady0);
            end
            if (i < 2) tick();
        end
        outReady0 = 1'b1;
        tick();
        vectorsApplied++;
        if ({outValid0, busy0} !== {1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL stall_done: got v=%b b=%b, want v=0 b=0", outValid0, busy0);
        end
    endtask

    task automatic test_zero_vector();
        inValid0 = 1'b1; inVec0 = 8'h00; outReady0 = 1'b1;
        vectorsApplied++;
        if (inReady0 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL zero_ready: got rdy=%b, want rdy=1", inReady0);
        end
        tick();
        vectorsApplied++;
        if ({outValid0, busy0, inReady0} !== {1'b0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL zero_drop: got v=%b b=%b rdy=%b, want v=0 b=0 rdy=1", outValid0, busy0, inReady0);
        end
        inVec0 = 8'h10;
        tick();
        inValid0 = 1'b0; inVec0 = 8'h00;
        vectorsApplied++;
        if ({outValid0, outCode0, outLast0} !== {1'b1, 3'd4, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL zero_single: got v=%b c=%0d l=%b, want v=1 c=4 l=1", outValid0, outCode0, outLast0);
        end
        tick();
        vectorsApplied++;
        if (outValid0 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL zero_after: got v=%b, want v=0", outValid0);
        end
    endtask

    task automatic test_back_to_back();
        inValid0 = 1'b1; inVec0 = 8'h03; outReady0 = 1'b1;
        tick();
        inVec0 = 8'h40;
        vectorsApplied++;
        if ({outValid0, outCode0, outLast0} !== {1'b1, 3'd0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL b2b_code0: got v=%b c=%0d l=%b, want v=1 c=0 l=0", outValid0, outCode0, outLast0);
        end
        tick();
        vectorsApplied++;
        if ({outValid0, outCode0, outLast0} !== {1'b1, 3'd1, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL b2b_code1: got v=%b c=%0d l=%b, want v=1 c=1 l=1", outValid0, outCode0, outLast0);
        end
        tick();
`ifndef ENC_BACK_TO_BACK_EN
        vectorsApplied++;
        if ({outValid0, inReady0} !== {1'b0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL b2b_gap: got v=%b rdy=%b, want v=0 rdy=1", outValid0, inReady0);
        end
        tick();
`endif
        inValid0 = 1'b0; inVec0 = 8'h00;
        vectorsApplied++;
        if ({outValid0, outCode0, outLast0} !== {1'b1, 3'd6, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL b2b_code6: got v=%b c=%0d l=%b, want v=1 c=6 l=1", outValid0, outCode0, outLast0);
        end
        tick();
        vectorsApplied++;
        if ({outValid0, busy0} !== {1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL b2b_done: got v=%b b=%b, want v=0 b=0", outValid0, busy0);
        end
    endtask

    task automatic test_msb_first();
        inValid1 = 1'b1; inVec1 = 8'hFF; outReady1 = 1'b1;
        tick();
        inValid1 = 1'b0; inVec1 = 8'h00;
        for (int i = 0; i < 8; i++) begin
            vectorsApplied++;
            if ({outValid1, outCode1, outLast1, busy1} !== {1'b1, 3'(7 - i), (i == 7), 1'b1}) begin
                miscompares++;
                $display("[TB] FAIL msb_beat[%0d]: got v=%b c=%0d l=%b b=%b, want v=1 c=%0d l=%b b=1",
                         i, outValid1, outCode1, outLast1, busy1, 7 - i, (i == 7));
            end
            tick();
        end
        vectorsApplied++;
        if ({outValid1, busy1} !== {1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL msb_busy_fall: got v=%b b=%b, want v=0 b=0", outValid1, busy1);
        end
    endtask

    initial begin
        rst = 1'b1;
        inValid0 = 1'b0; inVec0 = 8'h00; outReady0 = 1'b0;
        inValid1 = 1'b0; inVec1 = 8'h00; outReady1 = 1'b0;
        #1;
        test_reset();
        test_basic_scan();
        test_stall();
        test_zero_vector();
        test_back_to_back();
        test_msb_first();
        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
